// File: rtl/bist_ctrl_s820.sv
// BIST driver/observer for the s820 CUT: LFSR stimulus, MISR compaction.
// Optional BIST_SIG_OUT_EN exposes the running signature and pattern index.
module bist_ctrl_s820 #(
    parameter int          PI_W     = 18,
    parameter int          PO_W     = 19,
    parameter int          NUM_PAT  = 256,
    parameter int          INIT_CYC = 2,
    parameter logic [23:0] SEED     = 24'h000001,
    parameter logic [23:0] GOLDEN   = 24'h000000
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            cut_clr,
    output logic [PI_W-1:0] cut_pi,
    input  logic [PO_W-1:0] cut_po
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [23:0]     sig,
    output logic [15:0]     pat_idx
`endif
);

    typedef enum logic [2:0] {IDLE, INIT, RUN, CMP, DONE} state_t;

    localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
    localparam logic [15:0] PAT_LAST  = 16'(NUM_PAT - 1);

    state_t      state, state_n;
    logic [23:0] lfsr, lfsr_n;
    logic [23:0] misr, misr_n;
    logic [15:0] cnt, cnt_n;
    logic        pass_q, pass_n;
    logic [23:0] po_ext;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            lfsr   <= SEED;
            misr   <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_n;
            lfsr   <= lfsr_n;
            misr   <= misr_n;
            cnt    <= cnt_n;
            pass_q <= pass_n;
        end
    end

    always_comb begin
        po_ext = '0;
        po_ext[PO_W-1:0] = cut_po;
    end

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        misr_n  = misr;
        cnt_n   = cnt;
        pass_n  = pass_q;
        busy    = 1'b0;
        done    = 1'b0;
        pass    = 1'b0;
        cut_clr = 1'b1;
        cut_pi  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = INIT;
                    lfsr_n  = SEED;
                    misr_n  = '0;
                    cnt_n   = '0;
                end
            end
            INIT: begin
                busy = 1'b1;
                if (!start) begin
                    state_n = IDLE;
                end else if (cnt == INIT_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RUN: begin
                busy    = 1'b1;
                cut_clr = 1'b0;
                cut_pi  = lfsr[PI_W-1:0];
                if (!start) begin
                    state_n = IDLE;
                end else begin
                    // CUT response to pattern k is captured on the same edge
                    lfsr_n = {lfsr[22:0],
                              lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
                    misr_n = {misr[22:0],
                              misr[23] ^ misr[22] ^ misr[21] ^ misr[16]} ^ po_ext;
                    cnt_n  = cnt + 16'd1;
                    if (cnt == PAT_LAST)
                        state_n = CMP;
                end
            end
            CMP: begin
                busy = 1'b1;
                if (!start) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                    pass_n  = (misr == GOLDEN);
                end
            end
            DONE: begin
                done = 1'b1;
                pass = pass_q;
                if (!start) begin
                    state_n = IDLE;
                    pass_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef BIST_SIG_OUT_EN
    assign sig     = misr;
    assign pat_idx = (state == RUN) ? cnt : 16'd0;
`endif

endmodule
